// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the MEM-stage load/store unit
//
// Contents:
//   F3_*        RV32I load/store width codes
//   BE_*        write lane-mask constants
//   lsu_state_t FSM state encoding
//   f3_legal    funct3 + alignment legality check
//   store_be    store lane mask from width and address
//   store_wdata size-masked, lane-unshifted store data
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } lsu_state_t;

    // Unsigned widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic f3_legal(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3)
            F3_B:    be = BE_B << addr_lo;
            F3_H:    be = addr_lo[1] ? BE_HHI : BE_HLO;
            default: be = BE_W;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] data);
        logic [31:0] wd;
        case (f3)
            F3_B:    wd = {24'b0, data[7:0]};
            F3_H:    wd = {16'b0, data[15:0]};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select and sign/zero extension
//
// Ports:
//   i_word     32  raw memory word
//   i_addr_lo  2   byte offset of the load within the word
//   i_funct3   3   load width/sign code
//   o_data     32  extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'b0, w_byte};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store initiator for a registered-read data memory
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_req_valid / o_req_ready       request handshake (ready only while idle)
//   i_req_is_store, i_req_funct3    access kind and width
//   i_req_addr, i_req_wdata         byte address and store data
//   o_resp_valid, o_resp_rdata      one-cycle completion pulse, extended load data
//   o_resp_err                      misaligned / illegal funct3, no memory access made
//   o_mem_rd, o_mem_wr              one-cycle memory strobes
//   o_mem_addr, o_mem_wdata         byte address, size-masked unshifted store data
//   o_mem_byte_en                   write lane mask (zero on reads)
//   i_mem_rdata                     read word, valid the cycle after o_mem_rd
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_is_store,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_byte_en,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    lsu_state_t            r_state;
    logic                  r_req_ready;
    logic                  r_is_store;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_byte_en;

    logic                  w_accept;
    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_load_data;

    // r_req_ready mirrors "state is IDLE" but stays low while reset is asserted.
    assign w_accept = i_req_valid && r_req_ready;
    assign w_legal  = f3_legal(i_req_is_store, i_req_funct3, i_req_addr[1:0]);

    lsu_load_align u_align (
        .i_word    (i_mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b0;
            r_is_store    <= 1'b0;
            r_funct3      <= 3'b0;
            r_addr_lo     <= 2'b0;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_byte_en <= BE_NONE;
        end else begin
            // Pulses default low; each state re-asserts what it needs.
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        if (!w_legal) begin
                            // Rejected without touching memory; unit stays idle.
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state       <= ISSUE;
                            r_req_ready   <= 1'b0;
                            r_is_store    <= i_req_is_store;
                            r_funct3      <= i_req_funct3;
                            r_addr_lo     <= i_req_addr[1:0];
                            r_mem_rd      <= !i_req_is_store;
                            r_mem_wr      <= i_req_is_store;
                            r_mem_addr    <= i_req_addr;
                            r_mem_wdata   <= i_req_is_store ? store_wdata(i_req_funct3, i_req_wdata) : '0;
                            r_mem_byte_en <= i_req_is_store ? store_be(i_req_funct3, i_req_addr[1:0]) : BE_NONE;
                        end
                    end
                end
                ISSUE: begin
                    if (r_is_store) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        // Memory registers the word on this edge; sample it next edge.
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_rdata  = r_resp_rdata;
    assign o_resp_err    = r_resp_err;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_wr      = r_mem_wr;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_byte_en = r_mem_byte_en;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_is_store(req_is_store),
        .i_req_funct3  (req_funct3),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_resp_valid  (resp_valid),
        .o_resp_rdata  (resp_rdata),
        .o_resp_err    (resp_err),
        .o_mem_rd      (mem_rd),
        .o_mem_wr      (mem_wr),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_byte_en (mem_byte_en),
        .i_mem_rdata   (mem_rdata)
    );

    // Bus-side memory: registered read, byte-enabled write taking the low bytes of wdata.
    logic [31:0] tb_mem [0:63];
    logic [31:0] wr_word;
    int          wr_shift;

    always @(posedge clk) begin
        if (mem_wr) begin
            wr_shift = 0;
            for (int k = 3; k >= 0; k--) if (mem_byte_en[k]) wr_shift = k;
            wr_word = tb_mem[mem_addr[7:2]];
            for (int k = 0; k < 4; k++)
                if (mem_byte_en[k]) wr_word[8*k +: 8] = mem_wdata[8*(k-wr_shift) +: 8];
            tb_mem[mem_addr[7:2]] <= wr_word;
        end
        if (mem_rd) mem_rdata <= tb_mem[mem_addr[7:2]];
    end

    // Reference model: flat byte array and arithmetic on access sizes.
    logic [7:0] ref_mem [0:255];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (st) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return ok && ((a % acc_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        longint v = 0;
        int n = acc_size(f3);
        for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m = 0;
        for (int i = 0; i < acc_size(f3); i++) m = m | (32'd1 << ((a % 4) + i));
        return m;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] wd);
        longint mask = (longint'(1) << (8*acc_size(f3))) - 1;
        longint v = longint'(wd) & mask;
        return v[31:0];
    endfunction

    // Drives one request and observes the bus until a few cycles past the response.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output bit got, output int lat, output int rd_cnt, output int wr_cnt,
                          output int both_cnt, output logic [31:0] o_be, output logic [31:0] o_wd,
                          output logic [31:0] o_addr, output logic [31:0] o_rdata, output logic o_err);
        bit acc = 0;
        got = 0; lat = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        o_be = 'x; o_wd = 'x; o_addr = 'x; o_rdata = 'x; o_err = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: req_ready never 1 for addr 0x%08h", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            if (mem_rd && mem_wr) both_cnt++;
            if (mem_rd) begin rd_cnt++; o_addr = mem_addr; o_be = {28'b0, mem_byte_en}; end
            if (mem_wr) begin wr_cnt++; o_addr = mem_addr; o_be = {28'b0, mem_byte_en}; o_wd = mem_wdata; end
            if (resp_valid && !got) begin got = 1; lat = cyc; o_rdata = resp_rdata; o_err = resp_err; end
        end
    endtask

    task automatic check_op(input string tag, input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input bit e_err, input logic [31:0] e_rd,
                            input logic [31:0] e_be, input logic [31:0] e_wd);
        bit got; int lat, rdc, wrc, bothc;
        logic [31:0] obe, owd, oad, ord; logic oerr;
        do_req(st, f3, a, wd, got, lat, rdc, wrc, bothc, obe, owd, oad, ord, oerr);
        chk({tag, ".resp"}, 32'(got), 32'd1);
        chk({tag, ".err"}, 32'(oerr), 32'(e_err));
        chk({tag, ".rdata"}, ord, e_rd);
        chk({tag, ".latency"}, lat, e_err ? 32'd1 : (st ? 32'd2 : 32'd3));
        chk({tag, ".rd_cycles"}, rdc, (!e_err && !st) ? 32'd1 : 32'd0);
        chk({tag, ".wr_cycles"}, wrc, (!e_err && st) ? 32'd1 : 32'd0);
        chk({tag, ".both_strobes"}, bothc, 32'd0);
        if (!e_err) begin
            chk({tag, ".addr"}, oad, a);
            chk({tag, ".byte_en"}, obe, st ? e_be : 32'd0);
            if (st) begin
                chk({tag, ".wdata"}, owd, e_wd);
                for (int i = 0; i < acc_size(f3); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end
        end
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] be;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [16];

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, ".mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, ".mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".byte_en"}, 32'(mem_byte_en), 32'd0);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e1, e2;
        bit acc;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
        mem_rdata = 32'h0;

        vecs[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        32'hF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 3'd2, 32'h10, 32'h80FF7F01, 1'b0, 32'h0,        32'hF, 32'h80FF7F01};
        vecs[3]  = '{1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h13, 32'h0,        1'b0, 32'h00000080, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 3'd0, 32'h10, 32'h0,        1'b0, 32'h00000001, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 3'd1, 32'h12, 32'h1234ABCD, 1'b0, 32'h0,        32'hC, 32'h0000ABCD};
        vecs[7]  = '{1'b0, 3'd1, 32'h12, 32'h0,        1'b0, 32'hFFFFABCD, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 3'd5, 32'h12, 32'h0,        1'b0, 32'h0000ABCD, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 3'd2, 32'h11, 32'h0,        1'b1, 32'h0,        32'h0, 32'h0};
        vecs[10] = '{1'b1, 3'd1, 32'h13, 32'h5555,     1'b1, 32'h0,        32'h0, 32'h0};
        vecs[11] = '{1'b0, 3'd3, 32'h10, 32'h0,        1'b1, 32'h0,        32'h0, 32'h0};
        vecs[12] = '{1'b1, 3'd4, 32'h10, 32'h77,       1'b1, 32'h0,        32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'd1, 32'h11, 32'h0,        1'b1, 32'h0,        32'h0, 32'h0};
        vecs[14] = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hABCD7F01, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 3'd0, 32'h17, 32'h123456A5, 1'b0, 32'h0,        32'h8, 32'h000000A5};

        // Reset state
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("reset.ready_after_release", 32'(req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 16; i++)
            check_op($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                     vecs[i].err, vecs[i].rdata, vecs[i].be, vecs[i].wd);

        // req_valid held high across a load; second request waits for the response.
        e1 = ref_load(3'd2, 32'h10);
        e2 = ref_load(3'd4, 32'h13);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        chk("b2b.first_accept", 32'(acc), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_funct3 = 3'd4; req_addr = 32'h13;
        chk("b2b.ready_issue", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b.ready_capture", 32'(req_ready), 32'd0);
        chk("b2b.no_early_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("b2b.resp1_valid", 32'(resp_valid), 32'd1);
        chk("b2b.resp1_rdata", resp_rdata, e1);
        chk("b2b.ready_after", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.second_issue_rd", 32'(mem_rd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b.resp2_valid", 32'(resp_valid), 32'd1);
        chk("b2b.resp2_rdata", resp_rdata, e2);

        // Reset asserted while the load is in CAPTURE drops the access.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h14;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        chk("rst_mid.accept", 32'(acc), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid.no_resp%0d", i), 32'(resp_valid), 32'd0);
        end
        chk("rst_mid.ready", 32'(req_ready), 32'd1);
        check_op("rst_mid.sb", 1'b1, 3'd0, 32'h21, 32'h0000005A, 1'b0, 32'h0, 32'h2, 32'h5A);
        check_op("rst_mid.lbu", 1'b0, 3'd4, 32'h21, 32'h0, 1'b0, 32'h5A, 32'h0, 32'h0);

        // Randomized traffic against the byte-array model
        for (int n = 0; n < 80; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            bit          e_err;
            st    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            a     = 32'($urandom_range(0, 63));
            wd    = $urandom;
            e_err = !ref_legal(st, f3, a);
            check_op($sformatf("rnd%0d", n), st, f3, a, wd, e_err,
                     (!e_err && !st) ? ref_load(f3, a) : 32'h0,
                     ref_be(f3, a), ref_wd(f3, wd));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
